// File: rtl/writeback_pipe_pkg.sv
// Shared types and constants for the writeback pipe: stage-entry struct,
// flag bit positions and register-file geometry.
package writeback_pipe_pkg;

  localparam int REG_COUNT = 4;
  localparam int DST_W     = $clog2(REG_COUNT);

  localparam int CZN_C = 0;
  localparam int CZN_Z = 1;
  localparam int CZN_N = 2;

  typedef struct packed {
    logic             valid;
    logic [7:0]       data;
    logic [DST_W-1:0] dst;
    logic             wen;
    logic             flag_en;
    logic             carry;
  } wb_entry_t;

endpackage

// File: rtl/writeback_pipe_stage_reg.sv
// One writeback pipe stage: captures an entry every cycle, flush kills it.
module wb_stage_reg
  import writeback_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  wb_entry_t i_d,
  output wb_entry_t o_q
);

  wb_entry_t r_q;
  wb_entry_t w_next;

  always_comb begin
    w_next       = i_d;
    w_next.valid = i_d.valid & ~flush;
  end

  // Every field clears on reset so the write port reads all-zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= '0;
    else      r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/writeback_pipe.sv
// Two-stage writeback pipe with register-file write port, CZN flags and
// operand bypass. Define WB_FORWARD_EN to enable bypassing; otherwise a hazard stall is raised.
module writeback_pipe
  import writeback_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [DST_W-1:0] in_dst,
  input  logic             in_wen,
  input  logic             in_flag_en,
  input  logic             in_carry,
  input  logic             flush,
  input  logic [DST_W-1:0] rd_reg1,
  input  logic [DST_W-1:0] rd_reg2,
  input  logic [7:0]       rf_data1,
  input  logic [7:0]       rf_data2,
  output logic [DST_W-1:0] write_reg,
  output logic [7:0]       write_data,
  output logic             write_reg_en,
  output logic [2:0]       czn,
  output logic [7:0]       fwd_data1,
  output logic [7:0]       fwd_data2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic             hazard
);

  wb_entry_t w_in;
  wb_entry_t w_s1;
  wb_entry_t w_s2;
  logic [2:0] r_czn;

  assign w_in = '{valid: in_valid, data: in_data, dst: in_dst,
                  wen: in_wen, flag_en: in_flag_en, carry: in_carry};

  wb_stage_reg u_s1 (.clk(clk), .rst(rst), .flush(flush), .i_d(w_in), .o_q(w_s1));
  wb_stage_reg u_s2 (.clk(clk), .rst(rst), .flush(flush), .i_d(w_s1), .o_q(w_s2));

  // Flags follow the entry as it leaves S1; a flushed entry never touches them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_czn <= 3'b000;
    end else if (w_s1.valid && w_s1.flag_en && !flush) begin
      r_czn[CZN_C] <= w_s1.carry;
      r_czn[CZN_Z] <= (w_s1.data == 8'h00);
      r_czn[CZN_N] <= w_s1.data[7];
    end
  end

  assign czn          = r_czn;
  assign write_reg_en = w_s2.valid & w_s2.wen;
  assign write_reg    = w_s2.dst;
  assign write_data   = w_s2.data;

  logic w_unused_s2;
  assign w_unused_s2 = ^{w_s2.flag_en, w_s2.carry};

  logic [DST_W-1:0] w_rd  [2];
  logic [7:0]       w_rf  [2];
  logic [7:0]       w_fwd [2];
  logic             w_hit [2];
  logic             w_haz [2];

  assign w_rd[0] = rd_reg1;
  assign w_rd[1] = rd_reg2;
  assign w_rf[0] = rf_data1;
  assign w_rf[1] = rf_data2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic w_m1;
      logic w_m2;
      assign w_m1 = w_s1.valid & w_s1.wen & (w_s1.dst == w_rd[gi]);
      assign w_m2 = w_s2.valid & w_s2.wen & (w_s2.dst == w_rd[gi]);
`ifdef WB_FORWARD_EN
      // S1 is the younger producer, so it takes priority over S2.
      assign w_fwd[gi] = w_m1 ? w_s1.data : (w_m2 ? w_s2.data : w_rf[gi]);
      assign w_hit[gi] = w_m1 | w_m2;
      assign w_haz[gi] = 1'b0;
`else
      assign w_fwd[gi] = w_rf[gi];
      assign w_hit[gi] = 1'b0;
      assign w_haz[gi] = w_m1 | w_m2;
`endif
    end
  endgenerate

  assign fwd_data1 = w_fwd[0];
  assign fwd_data2 = w_fwd[1];
  assign fwd_hit1  = w_hit[0];
  assign fwd_hit2  = w_hit[1];
  assign hazard    = w_haz[0] | w_haz[1];

endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe: directed scenarios then random traffic.
module tb_writeback_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_dst = 2'd0;
  logic       in_wen = 1'b0;
  logic       in_flag_en = 1'b0;
  logic       in_carry = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] rd_reg1 = 2'd0;
  logic [1:0] rd_reg2 = 2'd0;
  logic [7:0] rf_data1 = 8'h00;
  logic [7:0] rf_data2 = 8'h00;
  logic [1:0] write_reg;
  logic [7:0] write_data;
  logic       write_reg_en;
  logic [2:0] czn;
  logic [7:0] fwd_data1;
  logic [7:0] fwd_data2;
  logic       fwd_hit1;
  logic       fwd_hit2;
  logic       hazard;

  writeback_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dst(in_dst),
    .in_wen(in_wen), .in_flag_en(in_flag_en), .in_carry(in_carry), .flush(flush),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .write_reg(write_reg), .write_data(write_data), .write_reg_en(write_reg_en),
    .czn(czn), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_hit1(fwd_hit1),
    .fwd_hit2(fwd_hit2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // An instruction in flight: accepted at some edge, not yet retired.
  typedef struct {
    bit       v;
    bit [7:0] data;
    bit [1:0] dst;
    bit       wen;
    bit       fe;
    bit       c;
  } ins_t;

  // An expected register-file write, due during the cycle after edge 'due'.
  typedef struct {
    int       due;
    bit [1:0] dst;
    bit [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  ins_t young;   // accepted at the last edge, not yet written
  ins_t old;     // currently presenting its write
  bit [2:0] m_czn = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: registered outputs, sampled at the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("write_en", write_reg_en, 1);
        check("write_reg", write_reg, exp_q[0].dst);
        check("write_data", write_data, exp_q[0].data);
        $display("cycle %0d write r%0d <= %02h czn=%03b", cyc, write_reg, write_data, czn);
        void'(exp_q.pop_front());
      end else begin
        check("write_en_idle", write_reg_en, 0);
      end
      check("czn", czn, m_czn);
    end
  end

  function automatic bit uses(input ins_t e, input bit [1:0] r);
    return e.v && e.wen && (e.dst == r);
  endfunction

  task automatic cycle(input bit v, input bit [7:0] d, input bit [1:0] dst, input bit wen,
                       input bit fe, input bit c, input bit fl, input bit rp);
    bit [1:0] r1, r2;
    bit [7:0] f1, f2;
    int e;
    @(negedge clk);
    #1;
    r1 = 2'($urandom_range(0, 3));
    r2 = 2'($urandom_range(0, 3));
    f1 = 8'($urandom);
    f2 = 8'($urandom);
    in_valid = v; in_data = d; in_dst = dst; in_wen = wen;
    in_flag_en = fe; in_carry = c; flush = fl;
    rd_reg1 = r1; rd_reg2 = r2; rf_data1 = f1; rf_data2 = f2;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_data1", fwd_data1, uses(young, r1) ? young.data : (uses(old, r1) ? old.data : f1));
    check("fwd_hit1", fwd_hit1, uses(young, r1) || uses(old, r1));
    check("fwd_data2", fwd_data2, uses(young, r2) ? young.data : (uses(old, r2) ? old.data : f2));
    check("fwd_hit2", fwd_hit2, uses(young, r2) || uses(old, r2));
    check("hazard", hazard, 0);
`else
    check("fwd_data1", fwd_data1, f1);
    check("fwd_data2", fwd_data2, f2);
    check("fwd_hit", {fwd_hit1, fwd_hit2}, 0);
    check("hazard", hazard, uses(young, r1) || uses(young, r2) || uses(old, r1) || uses(old, r2));
`endif
    if (rp) begin
      rst = 1'b0;
      #1;
      check("rst_write_en", write_reg_en, 0);
      check("rst_write_reg", write_reg, 0);
      check("rst_write_data", write_data, 0);
      check("rst_czn", czn, 0);
      $display("cycle %0d async reset pulse", cyc);
      young.v = 0; old.v = 0; m_czn = 3'b000;
      exp_q.delete();
      rst = 1'b1;
    end
    e = cyc + 1;
    if (fl) begin
      young.v = 0;
      old.v = 0;
    end else begin
      old = young;
      if (young.v && young.wen) exp_q.push_back('{due: e, dst: young.dst, data: young.data});
      if (young.v && young.fe) m_czn = {young.data[7], young.data == 8'h00, young.c};
      young = '{v: v, data: d, dst: dst, wen: wen, fe: fe, c: c};
    end
    @(posedge clk);
  endtask

  initial begin
    young = '{default: 0};
    old   = '{default: 0};
    #2;
    check("reset_write_en", write_reg_en, 0);
    check("reset_write_reg", write_reg, 0);
    check("reset_write_data", write_data, 0);
    check("reset_czn", czn, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // single write to r2, visible one cycle only
    cycle(1, 8'h3C, 2, 1, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    // flag updates: zero with carry, then negative
    cycle(1, 8'h00, 1, 0, 1, 1, 0, 0);
    cycle(1, 8'h80, 1, 0, 1, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    // back-to-back writes to the same register
    cycle(1, 8'h11, 1, 1, 0, 0, 0, 0);
    cycle(1, 8'h22, 1, 1, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    // flush with both stages full and flagging
    cycle(1, 8'h05, 0, 1, 1, 1, 0, 0);
    cycle(1, 8'hF0, 3, 1, 1, 0, 0, 0);
    cycle(1, 8'h77, 2, 1, 1, 1, 1, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    // reset while S2 is presenting a write
    cycle(1, 8'h44, 0, 1, 1, 0, 0, 0);
    cycle(1, 8'h55, 0, 1, 1, 0, 0, 0);
    cycle(1, 8'h66, 3, 1, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
